spi_master_rx: RTL and testbench

- SPI master receive stage. Sits directly downstream of the SPI slave transmitter; drives sclk/cs and captures the slave's miso stream.
- Deserialises words MSB-first into a small first-word-fall-through FIFO and presents them on a valid/ready interface to on-chip consumers.
- FIFO occupancy throttles the SPI link, so no received word is ever dropped.

---
 rtl/spi_master_rx_if.sv | 35 +++
 rtl/spi_master_rx.sv | 218 +++++++++++++++++++++
 tb/tb_spi_master_rx.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_rx_if.sv
// Bus bundle for spi_master_rx: SPI pins plus the receive valid/ready stream.
// rx_count is present only when SPI_MASTER_RX_COUNT_EN is defined.
interface spi_master_rx_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic              rx_enable;
  logic              miso;
  logic              sclk;
  logic              cs;
  logic              busy;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
`ifdef SPI_MASTER_RX_COUNT_EN
  logic [15:0]       rx_count;

  modport master (
    input  rx_enable, miso, dout_ready,
    output sclk, cs, busy, dout, dout_valid, rx_count
  );
  modport slave (
    output rx_enable, miso, dout_ready,
    input  sclk, cs, busy, dout, dout_valid, rx_count
  );
`else
  modport master (
    input  rx_enable, miso, dout_ready,
    output sclk, cs, busy, dout, dout_valid
  );
  modport slave (
    output rx_enable, miso, dout_ready,
    input  sclk, cs, busy, dout, dout_valid
  );
`endif
endinterface

// File: rtl/spi_master_rx.sv
// SPI mode-0 master receiver: MSB-first deserialiser feeding a first-word-fall-through FIFO.
// A FIFO slot is reserved before each word starts, so words are never dropped.
// Optional: SPI_MASTER_RX_COUNT_EN adds a 16-bit count of pushed words (rx_count).
module spi_master_rx #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  spi_master_rx_if.master bus
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = $clog2(DATA_W + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_LAST,
    S_HOLD
  } state_t;

  state_t            r_state, w_state;
  logic [DIV_W-1:0]  r_div, w_div;
  logic [BIT_W-1:0]  r_bit, w_bit;
  logic              r_sclk, w_sclk;
  logic              r_cs, w_cs;
  logic              r_busy;
  logic [DATA_W-1:0] r_shreg, w_shreg;
  logic              r_rsv, w_rsv;
  logic              w_push;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_valid;

  logic              w_div_tc;
  logic              w_pop;
  logic              w_free_idle;
  logic              w_free_after_push;

  assign w_div_tc          = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_pop             = r_dout_valid && bus.dout_ready;
  assign w_count_nxt       = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_free_idle       = (r_count + CNT_W'(r_rsv)) < CNT_W'(FIFO_DEPTH);
  // Room for another word once the current one lands and any pop this cycle is taken
  assign w_free_after_push = (r_count + CNT_W'(1) - CNT_W'(w_pop)) < CNT_W'(FIFO_DEPTH);

  // FSM state and link registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_sclk  <= 1'b0;
      r_cs    <= 1'b1;
      r_busy  <= 1'b0;
      r_shreg <= '0;
      r_rsv   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_div   <= w_div;
      r_bit   <= w_bit;
      r_sclk  <= w_sclk;
      r_cs    <= w_cs;
      r_busy  <= ~w_cs;
      r_shreg <= w_shreg;
      r_rsv   <= w_rsv;
    end
  end

  // Next-state and link control
  always_comb begin
    w_state = r_state;
    w_div   = r_div;
    w_bit   = r_bit;
    w_sclk  = r_sclk;
    w_cs    = r_cs;
    w_shreg = r_shreg;
    w_rsv   = r_rsv;
    w_push  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cs   = 1'b1;
        w_sclk = 1'b0;
        if (bus.rx_enable && w_free_idle) begin
          w_state = S_SETUP;
          w_cs    = 1'b0;
          w_div   = '0;
          w_bit   = '0;
          w_rsv   = 1'b1;
        end
      end
      S_SETUP: begin
        if (w_div_tc) begin
          w_state = S_SHIFT;
          w_div   = '0;
        end else begin
          w_div = r_div + DIV_W'(1);
        end
      end
      S_SHIFT: begin
        if (w_div_tc) begin
          w_div  = '0;
          w_sclk = ~r_sclk;
          if (!r_sclk) begin
            w_shreg = {r_shreg[DATA_W-2:0], bus.miso};
            w_bit   = r_bit + BIT_W'(1);
            if (r_bit == BIT_W'(DATA_W - 1)) begin
              w_state = S_LAST;
            end
          end
        end else begin
          w_div = r_div + DIV_W'(1);
        end
      end
      S_LAST: begin
        if (r_sclk) begin
          if (w_div_tc) begin
            w_sclk = 1'b0;
            w_div  = '0;
          end else begin
            w_div = r_div + DIV_W'(1);
          end
        end else begin
          // Push cycle: one clk of the low phase is already spent, so resume the divider at 1
          w_push = 1'b1;
          w_bit  = '0;
          if (bus.rx_enable && w_free_after_push) begin
            w_state = S_SHIFT;
            w_div   = DIV_W'(1);
            w_rsv   = 1'b1;
          end else begin
            w_state = S_HOLD;
            w_cs    = 1'b1;
            w_div   = '0;
            w_rsv   = 1'b0;
          end
        end
      end
      S_HOLD: begin
        w_cs = 1'b1;
        if (w_div_tc) begin
          w_state = S_IDLE;
          w_div   = '0;
        end else begin
          w_div = r_div + DIV_W'(1);
        end
      end
      default: begin
        w_state = S_IDLE;
        w_cs    = 1'b1;
        w_sclk  = 1'b0;
      end
    endcase
  end

  // Receive FIFO; r_dout always mirrors the head entry and holds when empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= r_shreg;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count      <= w_count_nxt;
      r_dout_valid <= (w_count_nxt != '0);
      if (w_pop) begin
        if (r_count > CNT_W'(1)) begin
          r_dout <= r_mem[r_rd_ptr + PTR_W'(1)];
        end else if (w_push) begin
          r_dout <= r_shreg;
        end
      end else if ((r_count == '0) && w_push) begin
        r_dout <= r_shreg;
      end
    end
  end

  a_push_not_full: assert property (@(posedge clk) disable iff (!rst)
    w_push |-> (r_count < CNT_W'(FIFO_DEPTH)));

`ifdef SPI_MASTER_RX_COUNT_EN
  logic [15:0] r_rx_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_count <= '0;
    end else if (w_push) begin
      r_rx_count <= r_rx_count + 16'd1;
    end
  end

  assign bus.rx_count = r_rx_count;
`endif

  assign bus.sclk       = r_sclk;
  assign bus.cs         = r_cs;
  assign bus.busy       = r_busy;
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;

endmodule

// File: tb/tb_spi_master_rx.sv
// Scoreboarded bench for spi_master_rx: mode-0 slave model, sclk phase monitor, FIFO consumer.
module tb_spi_master_rx;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int          LIMIT      = 3000;

  logic clk;
  logic rst;

  spi_master_rx_if #(.DATA_W(DATA_W)) bus ();

  spi_master_rx #(
    .CLK_DIV   (CLK_DIV),
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] tx_q[$];
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [DATA_W-1:0] w);
    tx_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // Slave model: MSB on cs fall, next bit after each sclk fall
  int                s_done = 0;
  int                s_bit  = 0;
  logic              s_loaded = 1'b0;
  logic              s_prev_sclk = 1'b0;
  logic [DATA_W-1:0] s_word = '0;

  always begin
    @(posedge clk);
    #1;
    if (!rst || bus.cs) begin
      s_loaded = 1'b0;
    end else if (!s_loaded) begin
      s_word   = (tx_q.size() != 0) ? tx_q[0] : '0;
      s_bit    = DATA_W - 1;
      s_loaded = 1'b1;
      bus.miso = s_word[s_bit];
    end else if (s_prev_sclk && !bus.sclk) begin
      if (s_bit == 0) begin
        if (tx_q.size() != 0) void'(tx_q.pop_front());
        s_done++;
        s_word = (tx_q.size() != 0) ? tx_q[0] : '0;
        s_bit  = DATA_W - 1;
      end else begin
        s_bit--;
      end
      bus.miso = s_word[s_bit];
    end
    s_prev_sclk = bus.sclk;
  end

  // Link monitor: sclk phase lengths, edge counts, busy consistency
  int   cyc = 0;
  int   sclk_rises = 0;
  int   cs_rises = 0;
  int   cs_falls = 0;
  int   m_run = 0;
  logic m_fall_seen = 1'b0;
  logic m_prev_sclk = 1'b0;
  logic m_prev_cs = 1'b1;
  logic mon_en = 1'b1;

  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (rst && mon_en) begin
      if (bus.cs !== m_prev_cs) begin
        check("busy_vs_cs", 32'(bus.busy), 32'(!bus.cs));
        if (bus.cs) cs_rises++;
        else        cs_falls++;
      end
      if (bus.cs) m_fall_seen = 1'b0;
      if (bus.sclk !== m_prev_sclk) begin
        if (bus.sclk) begin
          sclk_rises++;
          if (m_fall_seen) check("sclk_low_phase", 32'(m_run), 32'(CLK_DIV));
        end else begin
          check("sclk_high_phase", 32'(m_run), 32'(CLK_DIV));
          m_fall_seen = 1'b1;
        end
        m_run = 1;
      end else begin
        m_run++;
      end
    end
    m_prev_cs   = bus.cs;
    m_prev_sclk = bus.sclk;
  end

  // Consumer: every accepted word must match the scoreboard head
  always @(negedge clk) begin
    if (rst && bus.dout_valid && bus.dout_ready) begin
      if (exp_q.size() == 0) check("sb_depth", 32'(exp_q.size()), 32'd1);
      else                   check("dout", 32'(bus.dout), 32'(exp_q.pop_front()));
    end
  end

  task automatic wait_done(input int target);
    int n = 0;
    while (s_done < target && n < LIMIT) begin @(negedge clk); n++; end
    if (s_done < target) check("wait_done_timeout", 32'(s_done), 32'(target));
  endtask

  task automatic wait_rises(input int target);
    int n = 0;
    while (sclk_rises < target && n < LIMIT) begin @(negedge clk); n++; end
    if (sclk_rises < target) check("wait_rises_timeout", 32'(sclk_rises), 32'(target));
  endtask

  task automatic wait_sb_empty();
    int n = 0;
    while (exp_q.size() != 0 && n < LIMIT) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) check("wait_sb_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int base;
    int t0;
    int n;
    int r0;
    int hi;

    rst            = 1'b0;
    bus.rx_enable  = 1'b0;
    bus.dout_ready = 1'b0;
    bus.miso       = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs",    32'(bus.cs),         32'd1);
    check("rst_sclk",  32'(bus.sclk),       32'd0);
    check("rst_busy",  32'(bus.busy),       32'd0);
    check("rst_dout",  32'(bus.dout),       32'd0);
    check("rst_valid", 32'(bus.dout_valid), 32'd0);
`ifdef SPI_MASTER_RX_COUNT_EN
    check("rst_rx_count", 32'(bus.rx_count), 32'd0);
`endif
    rst = 1'b1;
    @(negedge clk);

    // Single word with latency and deselect time
    send(8'hA5);
    sclk_rises    = 0;
    bus.rx_enable = 1'b1;
    n = 0;
    while (bus.cs && n < LIMIT) begin @(negedge clk); n++; end
    check("single_cs_low", 32'(bus.cs), 32'd0);
    t0 = cyc;
    bus.rx_enable = 1'b0;
    n = 0;
    while (!bus.dout_valid && n < LIMIT) begin @(negedge clk); n++; end
    check("single_latency", 32'(cyc - t0), 32'(CLK_DIV + 2 * DATA_W * CLK_DIV + 1));
    check("single_dout",   32'(bus.dout),  32'h0000_00A5);
    check("single_rises",  32'(sclk_rises), 32'(DATA_W));
    hi = 0;
    for (int i = 0; i < int'(CLK_DIV) + 2; i++) begin
      if (bus.cs) hi++;
      @(negedge clk);
    end
    check("single_cs_high", 32'(hi), 32'(CLK_DIV + 2));
    bus.dout_ready = 1'b1;
    wait_sb_empty();
    repeat (10) @(negedge clk);

    // Back-to-back stream
    send(8'h3C); send(8'h81); send(8'hFF);
    base = s_done;
    r0   = cs_rises;
    bus.rx_enable = 1'b1;
    wait_done(base + 2);
    repeat (8) @(negedge clk);
    bus.rx_enable = 1'b0;
    wait_done(base + 3);
    check("stream_cs_rises", 32'(cs_rises - r0), 32'd0);
    check("stream_cs_low",   32'(bus.cs),        32'd0);
    wait_sb_empty();
    repeat (20) @(negedge clk);

    // Backpressure: FIFO fills, link stalls, then drains and resumes
    bus.dout_ready = 1'b0;
    for (int i = 1; i <= 6; i++) send(8'(i));
    base = s_done;
    bus.rx_enable = 1'b1;
    wait_done(base + FIFO_DEPTH);
    repeat (20) @(negedge clk);
    r0 = sclk_rises;
    repeat (40) @(negedge clk);
    check("bp_cs_high",    32'(bus.cs),             32'd1);
    check("bp_sclk_low",   32'(bus.sclk),           32'd0);
    check("bp_words",      32'(s_done - base),      32'(FIFO_DEPTH));
    check("bp_no_sclk",    32'(sclk_rises - r0),    32'd0);
    check("bp_head",       32'(bus.dout),           32'd1);
    check("bp_valid",      32'(bus.dout_valid),     32'd1);
    bus.dout_ready = 1'b1;
    wait_done(base + 5);
    repeat (8) @(negedge clk);
    bus.rx_enable = 1'b0;
    wait_sb_empty();
    check("bp_total_words", 32'(s_done - base), 32'd6);
    repeat (20) @(negedge clk);

    // rx_enable dropped at bit 3
    send(8'h5A);
    sclk_rises    = 0;
    bus.rx_enable = 1'b1;
    wait_rises(3);
    bus.rx_enable = 1'b0;
    wait_sb_empty();
    r0 = cs_falls;
    repeat (40) @(negedge clk);
    check("drop_no_setup", 32'(cs_falls - r0), 32'd0);
    check("drop_cs_high",  32'(bus.cs),        32'd1);
`ifdef SPI_MASTER_RX_COUNT_EN
    check("rx_count_11", 32'(bus.rx_count), 32'd11);
`endif

    // Reset mid-word, then clean reception
    send(8'h77);
    send(8'hC3); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    sclk_rises    = 0;
    bus.rx_enable = 1'b1;
    wait_rises(5);
    #2;
    rst    = 1'b0;
    mon_en = 1'b0;
    #1;
    check("mid_rst_cs",    32'(bus.cs),         32'd1);
    check("mid_rst_sclk",  32'(bus.sclk),       32'd0);
    check("mid_rst_valid", 32'(bus.dout_valid), 32'd0);
    check("mid_rst_busy",  32'(bus.busy),       32'd0);
`ifdef SPI_MASTER_RX_COUNT_EN
    check("mid_rst_rx_count", 32'(bus.rx_count), 32'd0);
`endif
    void'(tx_q.pop_front());
    void'(exp_q.pop_front());
    repeat (2) @(negedge clk);
    m_run       = 0;
    m_fall_seen = 1'b0;
    m_prev_sclk = 1'b0;
    m_prev_cs   = 1'b1;
    mon_en      = 1'b1;
    base        = s_done;
    rst         = 1'b1;
    wait_done(base + 4);
    repeat (8) @(negedge clk);
    bus.rx_enable = 1'b0;
    wait_sb_empty();
    check("post_rst_words", 32'(s_done - base), 32'd5);
`ifdef SPI_MASTER_RX_COUNT_EN
    check("rx_count_5", 32'(bus.rx_count), 32'd5);
`endif
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
